// File: rtl/ram_mfc_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_mfc_responder_pkg
// Purpose  : Shared encodings for the MAR/MDR memory responder: access size,
//            transfer direction, FSM states and a big-endian lane picker.
// Revision : 1.0 - initial release
// ============================================================================
package ram_mfc_responder_pkg;

    localparam logic [1:0] WS_BYTE  = 2'b00;
    localparam logic [1:0] WS_HALF  = 2'b01;
    localparam logic [1:0] WS_WORD  = 2'b10;

    localparam logic       RW_READ  = 1'b1;
    localparam logic       RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte at offset off within a big-endian word (offset 0 is the MSB byte).
    function automatic logic [7:0] laneByte(input logic [31:0] word, input logic [1:0] off);
        return word[{~off, 3'b000} +: 8];
    endfunction

endpackage : ram_mfc_responder_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Maps access size and address offset onto the four big-endian
//            byte lanes of a word; flags misaligned halfword/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import ram_mfc_responder_pkg::*;
(
    input  logic [1:0]  i_wordSel,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_dataIn,
    input  logic [31:0] i_rdLanes,
    output logic [3:0]  o_byteWe,
    output logic [31:0] o_wrLanes,
    output logic        o_misalign,
    output logic [31:0] o_rdData
);

    // o_byteWe[i] enables byte offset i, carried on o_wrLanes[31-8*i -: 8].
    always_comb begin
        o_byteWe   = 4'b0000;
        o_wrLanes  = i_dataIn;
        o_misalign = 1'b0;
        o_rdData   = 32'h0000_0000;
        case (i_wordSel)
            WS_BYTE: begin
                o_wrLanes = {4{i_dataIn[7:0]}};
                o_byteWe  = 4'b0001 << i_addrLo;
                o_rdData  = {24'h00_0000, laneByte(i_rdLanes, i_addrLo)};
            end
            WS_HALF: begin
                o_wrLanes  = {2{i_dataIn[15:0]}};
                o_misalign = i_addrLo[0];
                if (!i_addrLo[0]) begin
                    o_byteWe = i_addrLo[1] ? 4'b1100 : 4'b0011;
                    o_rdData = {16'h0000, i_addrLo[1] ? i_rdLanes[15:0] : i_rdLanes[31:16]};
                end
            end
            default: begin
                // Reserved encoding 2'b11 behaves as a word access.
                o_misalign = |i_addrLo;
                if (i_addrLo == 2'b00) begin
                    o_byteWe = 4'b1111;
                    o_rdData = i_rdLanes;
                end
            end
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/ram_mfc_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_mfc_responder
// Purpose  : Byte-addressed big-endian RAM answering MAR/MDR requests with a
//            four-phase MOV/MFC handshake and programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module ram_mfc_responder
    import ram_mfc_responder_pkg::*;
#(
    parameter int    ADDR_W      = 8,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MOV,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       DataIn,
    input  logic [1:0]        WordSel,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Busy,
    output logic              AlignErr
);

    localparam int             DEPTH    = 2 ** ADDR_W;
    localparam int             CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            r_state;
    state_t            w_stateNext;
    logic              w_access;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [1:0]        r_ws;
    logic              r_mfc;
    logic              r_busy;
    logic              r_alignErr;
    logic [31:0]       r_dataOut;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] w_laneAddr [4];
    logic [31:0]       w_rdLanes;
    logic [3:0]        w_byteWe;
    logic [31:0]       w_wrLanes;
    logic              w_misalign;
    logic [31:0]       w_rdData;

    initial for (int i = 0; i < DEPTH; i++) r_mem[i] = 8'h00;

    // The four bytes of the word containing the latched address, MSB first.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_laneAddr[g]            = {r_addr[ADDR_W-1:2], 2'(g)};
        assign w_rdLanes[8*(3-g) +: 8]  = r_mem[w_laneAddr[g]];
    end

    mem_lane_align u_laneAlign (
        .i_wordSel  (r_ws),
        .i_addrLo   (r_addr[1:0]),
        .i_dataIn   (r_data),
        .i_rdLanes  (w_rdLanes),
        .o_byteWe   (w_byteWe),
        .o_wrLanes  (w_wrLanes),
        .o_misalign (w_misalign),
        .o_rdData   (w_rdData)
    );

    always_ff @(posedge Clk) begin
        if (Clr) r_state <= ST_IDLE;
        else     r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: if (MOV) w_stateNext = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: if (!MOV) w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_cnt      <= '0;
            r_rw       <= RW_READ;
            r_addr     <= '0;
            r_data     <= 32'h0;
            r_ws       <= WS_BYTE;
            r_mfc      <= 1'b0;
            r_busy     <= 1'b0;
            r_alignErr <= 1'b0;
            r_dataOut  <= 32'h0;
        end else begin
            if (r_state == ST_IDLE && MOV) begin
                r_rw   <= RW;
                r_addr <= Addr;
                r_data <= DataIn;
                r_ws   <= WordSel;
                r_cnt  <= CNT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt  <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_alignErr <= w_misalign;
                if (w_misalign)            r_dataOut <= 32'h0;
                else if (r_rw == RW_READ)  r_dataOut <= w_rdData;
            end
            r_mfc  <= (w_stateNext == ST_DONE);
            r_busy <= (w_stateNext != ST_IDLE);
        end
    end

    // Storage survives reset; Clr only blocks a write that has not yet committed.
    always_ff @(posedge Clk) begin
        if (!Clr && w_access && r_rw == RW_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byteWe[i]) r_mem[w_laneAddr[i]] <= w_wrLanes[8*(3-i) +: 8];
            end
        end
    end

    assign DataOut  = r_dataOut;
    assign MFC      = r_mfc;
    assign Busy     = r_busy;
    assign AlignErr = r_alignErr;

endmodule : ram_mfc_responder
`default_nettype wire

// File: tb/tb_ram_mfc_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_mfc_responder
// Purpose  : Directed bench for the MOV/MFC RAM responder (2 and 0 wait states).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_mfc_responder;
    import ram_mfc_responder_pkg::*;

    logic        clk = 1'b0;
    logic        clr, mov, rw;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [1:0]  ws;
    logic [31:0] doA, doB, oDo;
    logic        mfcA, mfcB, busyA, busyB, aeA, aeB, oMfc, oBusy, oAe;
    int          sel;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ram_mfc_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dutA (
        .Clk(clk), .Clr(clr), .MOV(mov), .RW(rw), .Addr(addr), .DataIn(din),
        .WordSel(ws), .DataOut(doA), .MFC(mfcA), .Busy(busyA), .AlignErr(aeA)
    );

    ram_mfc_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dutB (
        .Clk(clk), .Clr(clr), .MOV(mov), .RW(rw), .Addr(addr), .DataIn(din),
        .WordSel(ws), .DataOut(doB), .MFC(mfcB), .Busy(busyB), .AlignErr(aeB)
    );

    always_comb begin
        oDo   = (sel == 1) ? doB   : doA;
        oMfc  = (sel == 1) ? mfcB  : mfcA;
        oBusy = (sel == 1) ? busyB : busyA;
        oAe   = (sel == 1) ? aeB   : aeA;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One four-phase transaction; expected result queued at drive time.
    task automatic req(input string tag, input logic r, input logic [7:0] a,
                       input logic [31:0] d, input logic [1:0] w,
                       input logic [31:0] expD, input logic expE,
                       input int hold, input logic moveAddr);
        int   n;
        int   lat;
        exp_t e;
        lat  = (sel == 1) ? 2 : 4;
        rw   = r;
        addr = a;
        din  = d;
        ws   = w;
        mov  = 1'b1;
        sb.push_back('{d: expD, e: expE});
        n = 0;
        do begin
            tick();
            n++;
            if (moveAddr && n == 1) begin
                addr = a ^ 8'h20;
                din  = ~d;
            end
        end while (!oMfc && n < 20);
        check($sformatf("%s_lat", tag), 32'(n), 32'(lat));
        e = sb.pop_front();
        check($sformatf("%s_data", tag), oDo, e.d);
        check($sformatf("%s_aerr", tag), {31'b0, oAe}, {31'b0, e.e});
        for (int i = 0; i < hold; i++) begin
            tick();
            check($sformatf("%s_holdMfc", tag), {31'b0, oMfc}, 32'd1);
            check($sformatf("%s_holdData", tag), oDo, e.d);
        end
        mov = 1'b0;
        tick();
        check($sformatf("%s_mfcDrop", tag), {31'b0, oMfc}, 32'd0);
        check($sformatf("%s_busyDrop", tag), {31'b0, oBusy}, 32'd0);
    endtask

    initial begin
        sel  = 0;
        clr  = 1'b1;
        mov  = 1'b1;
        rw   = RW_READ;
        addr = 8'h00;
        din  = 32'h0;
        ws   = WS_WORD;
        tick();
        tick();
        check("rst_mfc",  {31'b0, mfcA},  32'd0);
        check("rst_busy", {31'b0, busyA}, 32'd0);
        check("rst_data", doA,            32'd0);
        check("rst_aerr", {31'b0, aeA},   32'd0);
        clr = 1'b0;
        mov = 1'b0;
        tick();

        req("wr_w10",  RW_WRITE, 8'h10, 32'hDEADBEEF, WS_WORD, 32'h0000_0000, 1'b0, 0, 1'b0);
        req("rd_w10",  RW_READ,  8'h10, 32'h0,        WS_WORD, 32'hDEADBEEF,  1'b0, 0, 1'b0);
        req("rd_b10",  RW_READ,  8'h10, 32'h0,        WS_BYTE, 32'h0000_00DE, 1'b0, 0, 1'b0);
        req("rd_b13",  RW_READ,  8'h13, 32'h0,        WS_BYTE, 32'h0000_00EF, 1'b0, 0, 1'b0);

        req("wr_w20",  RW_WRITE, 8'h20, 32'h11223344, WS_WORD, 32'h0000_00EF, 1'b0, 0, 1'b0);
        req("wr_h22",  RW_WRITE, 8'h22, 32'h1234ABCD, WS_HALF, 32'h0000_00EF, 1'b0, 0, 1'b0);
        req("rd_w20",  RW_READ,  8'h20, 32'h0,        WS_WORD, 32'h1122ABCD,  1'b0, 0, 1'b0);
        req("rd_h22",  RW_READ,  8'h22, 32'h0,        WS_HALF, 32'h0000_ABCD, 1'b0, 0, 1'b0);

        req("wr_w04",  RW_WRITE, 8'h04, 32'h01020304, WS_WORD, 32'h0000_ABCD, 1'b0, 0, 1'b0);
        req("wr_mis",  RW_WRITE, 8'h05, 32'hFFFFFFFF, WS_WORD, 32'h0000_0000, 1'b1, 0, 1'b0);
        req("rd_w04",  RW_READ,  8'h04, 32'h0,        WS_WORD, 32'h01020304,  1'b0, 0, 1'b0);
        req("rd_hmis", RW_READ,  8'h23, 32'h0,        WS_HALF, 32'h0000_0000, 1'b1, 0, 1'b0);

        // MOV held 10 cycles after MFC, address/data moved during WAIT.
        req("hold",    RW_READ,  8'h10, 32'h0,        WS_WORD, 32'hDEADBEEF,  1'b0, 10, 1'b1);

        req("wr_b30",  RW_WRITE, 8'h30, 32'h00000077, WS_BYTE, 32'hDEADBEEF,  1'b0, 0, 1'b0);
        rw   = RW_WRITE;
        addr = 8'h30;
        din  = 32'h00000055;
        ws   = WS_BYTE;
        mov  = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        check("abort_mfc",  {31'b0, mfcA},  32'd0);
        check("abort_busy", {31'b0, busyA}, 32'd0);
        check("abort_data", doA,            32'd0);
        clr = 1'b0;
        mov = 1'b0;
        tick();
        req("rd_b30",  RW_READ,  8'h30, 32'h0,        WS_BYTE, 32'h0000_0077, 1'b0, 0, 1'b0);

        sel = 1;
        req("z_wr_w40", RW_WRITE, 8'h40, 32'hCAFEF00D, WS_WORD, 32'h0000_0077, 1'b0, 0, 1'b0);
        req("z_rd_w40", RW_READ,  8'h40, 32'h0,        WS_WORD, 32'hCAFEF00D,  1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule : tb_ram_mfc_responder
`default_nettype wire
